// File: rtl/ram_bus_pkg.sv
// Shared types and default geometry for the RAM bus controller and its bus driver.
package ram_bus_pkg;

  localparam int AW_DEF      = 4;
  localparam int DW_DEF      = 4;
  localparam int RD_WAIT_DEF = 1;
  localparam int TURN_DEF    = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSETUP,
    S_WSTROBE,
    S_WHOLD,
    S_RACT,
    S_RSP,
    S_TURN
  } state_e;

endpackage

// File: rtl/ram_bus_iobuf.sv
// Tristate driver for the shared RAM data bus: drives dout when oe is high, always returns the bus level on din.
module ram_bus_iobuf
  import ram_bus_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          oe,
  input  logic [DW-1:0] dout,
  output logic [DW-1:0] din,
  inout  wire  [DW-1:0] ram_data
);

  assign ram_data = oe ? dout : {DW{1'bz}};
  assign din      = ram_data;

endmodule

// File: rtl/ram_bus_ctrl.sv
// Request/response front-end sequencing strobes and the shared data bus of a time-shared 16x4 RAM.
// Optional write read-back verification is enabled by defining RAM_BUS_CTRL_WVERIFY_EN.
module ram_bus_ctrl
  import ram_bus_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int TURN    = TURN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_read,
  output logic          ram_write,
  inout  wire  [DW-1:0] ram_data
);

  localparam int WW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam int TW = $clog2(TURN + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

  state_e        state, next;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] turn_cnt;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] din;
  logic          bus_oe;
  logic          rd_last;
  logic          vrf_pend;
  logic          wr_rsp_early;

  assign rd_last = (state == S_RACT) && (wait_cnt == WAIT_LAST);

`ifdef RAM_BUS_CTRL_WVERIFY_EN
  // A write is answered only after its read-back; vrf_done marks that the read-back has started.
  logic vrf_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      vrf_done <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      if (state == S_IDLE)
        vrf_done <= 1'b0;
      else if (state == S_TURN && next == S_RACT)
        vrf_done <= 1'b1;
      if (rd_last)
        wr_err <= we_q && (din != wdata_q);
    end
  end
  assign vrf_pend     = we_q && !vrf_done;
  assign wr_rsp_early = 1'b0;
`else
  assign vrf_pend     = 1'b0;
  assign wr_rsp_early = 1'b1;
  assign wr_err       = 1'b0;
`endif

  always_comb begin
    next = state;
    case (state)
      S_IDLE:    if (req_valid) next = req_we ? S_WSETUP : S_RACT;
      S_WSETUP:  next = S_WSTROBE;
      S_WSTROBE: next = S_WHOLD;
      S_WHOLD:   next = S_TURN;
      S_RACT:    if (rd_last) next = S_RSP;
      S_RSP:     next = S_TURN;
      S_TURN:    if (turn_cnt == TURN_LAST) next = vrf_pend ? S_RACT : S_IDLE;
      default:   next = S_IDLE;
    endcase
  end

  // Every bus-facing output is registered from the next state so strobes are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      bus_oe    <= 1'b0;
      wait_cnt  <= '0;
      turn_cnt  <= '0;
      we_q      <= 1'b0;
    end else begin
      state     <= next;
      req_ready <= (next == S_IDLE);
      ram_read  <= (next == S_RACT);
      ram_write <= (next == S_WSTROBE);
      bus_oe    <= next inside {S_WSETUP, S_WSTROBE, S_WHOLD};
      rsp_valid <= (next == S_RSP) || (wr_rsp_early && next == S_WHOLD);
      wait_cnt  <= (state == S_RACT && next == S_RACT) ? wait_cnt + 1'b1 : '0;
      turn_cnt  <= (state == S_TURN && next == S_TURN) ? turn_cnt + 1'b1 : '0;
      if (state == S_IDLE && req_valid) begin
        we_q     <= req_we;
        ram_addr <= req_addr;
      end
      if (rd_last)
        rsp_rdata <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid)
      wdata_q <= req_wdata;
  end

  ram_bus_iobuf #(.DW(DW)) u_io (
    .oe       (bus_oe),
    .dout     (wdata_q),
    .din      (din),
    .ram_data (ram_data)
  );

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Bench for ram_bus_ctrl: behavioural 16x4 RAM on the bus, per-cycle timing model per transaction, random traffic.
module tb_ram_bus_ctrl;

  localparam int AW      = 4;
  localparam int DW      = 4;
  localparam int RD_WAIT = 1;
  localparam int TURN    = 1;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          wr_err;
  logic [AW-1:0] ram_addr;
  logic          ram_read;
  logic          ram_write;
  wire  [DW-1:0] ram_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] stuck_mask;
  logic [DW-1:0] last_rdata;

  ram_bus_ctrl #(.AW(AW), .DW(DW), .RD_WAIT(RD_WAIT), .TURN(TURN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wr_err    (wr_err),
    .ram_addr  (ram_addr),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_data  (ram_data)
  );

  // Behavioural RAM: drives the bus while read is high, captures on the rising write strobe.
  assign ram_data = ram_read ? mem[ram_addr] : {DW{1'bz}};
  always @(posedge ram_write) mem[ram_addr] <= ram_data & stuck_mask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rw_excl", 32'(ram_read && ram_write), 32'd0);
      check_eq("rd_drive_excl", 32'(ram_read && dut.bus_oe), 32'd0);
    end
  end

  task automatic set_req(input logic we, input logic [3:0] a, input logic [3:0] d);
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
  endtask

  // Entered at a negedge with the request already on req_*; leaves at the negedge where ready returns.
  task automatic run_txn(input logic we, input logic [3:0] a, input logic [3:0] d,
                         input logic nv, input logic nwe, input logic [3:0] na, input logic [3:0] nd);
    int waitc;
    int k_rsp, k_done, rd0, rd1;
    logic [3:0] exp_rd;
    logic exp_err;
    logic exp_oe, exp_rdn;
    waitc = 0;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      check_eq("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    exp_err = 1'b0;
    if (we) begin
      ref_mem[a] = d & stuck_mask;
`ifdef RAM_BUS_CTRL_WVERIFY_EN
      rd0     = 4 + TURN;
      rd1     = 4 + TURN + RD_WAIT;
      k_rsp   = 5 + TURN + RD_WAIT;
      k_done  = 6 + 2 * TURN + RD_WAIT;
      exp_rd  = ref_mem[a];
      exp_err = (ref_mem[a] != d);
`else
      rd0    = 1;
      rd1    = 0;
      k_rsp  = 3;
      k_done = 4 + TURN;
      exp_rd = last_rdata;
`endif
    end else begin
      rd0    = 1;
      rd1    = 1 + RD_WAIT;
      k_rsp  = 2 + RD_WAIT;
      k_done = 3 + RD_WAIT + TURN;
      exp_rd = ref_mem[a];
    end
    @(negedge clk);
    req_valid = nv;
    req_we    = nwe;
    req_addr  = na;
    req_wdata = nd;
    for (int k = 1; k <= k_done; k++) begin
      if (k > 1) @(negedge clk);
      exp_oe  = we && (k <= 3);
      exp_rdn = (k >= rd0) && (k <= rd1);
      check_eq("ram_write", 32'(ram_write), 32'(we && k == 2));
      check_eq("ram_read", 32'(ram_read), 32'(exp_rdn));
      check_eq("bus_oe", 32'(dut.bus_oe), 32'(exp_oe));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(k == k_rsp));
      check_eq("req_ready", 32'(req_ready), 32'(k == k_done));
      check_eq("ram_addr", 32'(ram_addr), 32'(a));
      if (exp_oe)  check_eq("bus_wdata", 32'(ram_data), 32'(d));
      if (exp_rdn) check_eq("bus_rdata", 32'(ram_data), 32'(ref_mem[a]));
      if (k == k_rsp) begin
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check_eq("wr_err", 32'(wr_err), 32'(exp_err));
      end
    end
    last_rdata = exp_rd;
  endtask

  logic       hw [4];
  logic [3:0] ha [4];
  logic [3:0] hd [4];
  logic       cwe, nwe, nv;
  logic [3:0] ca, cd, na, nd;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    stuck_mask = 4'hF;
    last_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_wr_err", 32'(wr_err), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_read", 32'(ram_read), 32'd0);
    check_eq("rst_ram_write", 32'(ram_write), 32'd0);
    check_eq("rst_bus_oe", 32'(dut.bus_oe), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    set_req(1'b1, 4'd3, 4'hA);
    run_txn(1'b1, 4'd3, 4'hA, 1'b0, 1'b0, 4'd0, 4'd0);
    set_req(1'b0, 4'd3, 4'h0);
    run_txn(1'b0, 4'd3, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Four requests with req_valid held high throughout.
    hw[0] = 1'b1; ha[0] = 4'd5;  hd[0] = 4'h6;
    hw[1] = 1'b0; ha[1] = 4'd5;  hd[1] = 4'h1;
    hw[2] = 1'b1; ha[2] = 4'd12; hd[2] = 4'hC;
    hw[3] = 1'b0; ha[3] = 4'd3;  hd[3] = 4'h0;
    set_req(hw[0], ha[0], hd[0]);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) run_txn(hw[i], ha[i], hd[i], 1'b1, hw[i+1], ha[i+1], hd[i+1]);
      else       run_txn(hw[i], ha[i], hd[i], 1'b0, 1'b0, 4'd0, 4'd0);
    end

    // Reset asserted during the write strobe cycle.
    set_req(1'b1, 4'd3, 4'h9);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_strobe_seen", 32'(ram_write), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ram_write", 32'(ram_write), 32'd0);
    check_eq("abort_ram_read", 32'(ram_read), 32'd0);
    check_eq("abort_bus_oe", 32'(dut.bus_oe), 32'd0);
    check_eq("abort_ready", 32'(req_ready), 32'd1);
    check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
    check_eq("abort_ready2", 32'(req_ready), 32'd1);
    set_req(1'b1, 4'd3, 4'h7);
    run_txn(1'b1, 4'd3, 4'h7, 1'b0, 1'b0, 4'd0, 4'd0);

`ifdef RAM_BUS_CTRL_WVERIFY_EN
    stuck_mask = 4'hE;
    set_req(1'b1, 4'd7, 4'h5);
    run_txn(1'b1, 4'd7, 4'h5, 1'b0, 1'b0, 4'd0, 4'd0);
    stuck_mask = 4'hF;
`endif

    cwe = 1'($urandom_range(0, 1));
    ca  = 4'($urandom_range(0, 15));
    cd  = 4'($urandom_range(0, 15));
    set_req(cwe, ca, cd);
    for (int i = 0; i < 40; i++) begin
      nv  = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      nwe = 1'($urandom_range(0, 1));
      na  = 4'($urandom_range(0, 15));
      nd  = 4'($urandom_range(0, 15));
      run_txn(cwe, ca, cd, nv, nwe, na, nd);
      if (!nv && i < 39) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req_valid = 1'b1;
      end
      cwe = nwe;
      ca  = na;
      cd  = nd;
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
